// File: rtl/axis_hdr_pkg.sv
// Shared definitions for the AXI-Stream header-insertion family.
//   hdr_state_e : inserter FSM states (idle, streaming payload, flushing the residual)
//   popcount    : number of set lanes in a keep vector (zero-extend to MAX_BYTES)
//   keep_msk    : left-aligned keep mask with n lanes set in a bytes-lane beat
// MAX_BYTES bounds the supported beat width (1024-bit data).
package axis_hdr_pkg;

    localparam int unsigned MAX_BYTES = 128;

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StFlush
    } hdr_state_e;

    function automatic int unsigned popcount(input logic [MAX_BYTES-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

    // Bit i is lane i; the MSB lane (byte 0) is bit bytes-1.
    function automatic logic [MAX_BYTES-1:0] keep_msk(input int unsigned n,
                                                      input int unsigned bytes);
        logic [MAX_BYTES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_BYTES; i++) begin
            m[i] = (i < int'(bytes)) && (i >= int'(bytes) - int'(n));
        end
        return m;
    endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// Single-entry output register for a valid/ready stream.
//   clk, rst_n          : clock, asynchronous active-low reset (clears valid and data)
//   valid_in/data_in    : upstream beat
//   ready_in            : slice can take a beat (empty, or draining this cycle)
//   valid_out/data_out  : registered beat, held stable while stalled
//   ready_out           : downstream ready
module axis_reg_slice #(
    parameter int unsigned WIDTH = 37
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready_in,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out,
    input  logic             ready_out
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    assign ready_in  = !valid_q || ready_out;
    assign valid_out = valid_q;
    assign data_out  = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (valid_in && ready_in) begin
            valid_q <= 1'b1;
            data_q  <= data_in;
        end else if (ready_out) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_hdr_insert_gen.sv
// Prepends the valid bytes of one header word to every AXI-Stream packet and repacks the
// result into full-width, left-aligned beats.
//   clk, rst_n                               : clock, asynchronous active-low reset
//   valid_in/data_in/keep_in/last_in/ready_in : payload stream (byte 0 = MSB)
//   valid_out/data_out/keep_out/last_out/ready_out : repacked output stream (registered)
//   valid_hdr/data_hdr/keep_hdr/ready_hdr    : header word, valid bytes in the LSB lanes
// Optional (macro HDR_INS_PKT_CNT_EN):
//   pkt_cnt      : count of handshaken last_out beats, wraps at 2^32
//   hdr_drop_err : sticky, set when valid_hdr is seen with non-contiguous keep_hdr
module axis_hdr_insert_gen
    import axis_hdr_pkg::*;
#(
    parameter  int unsigned DATA_WD = 32,
    localparam int unsigned BYTES   = DATA_WD / 8,
    localparam int unsigned CNT_WD  = $clog2(BYTES + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_in,
    input  logic [DATA_WD-1:0] data_in,
    input  logic [BYTES-1:0]   keep_in,
    input  logic               last_in,
    output logic               ready_in,
    output logic               valid_out,
    output logic [DATA_WD-1:0] data_out,
    output logic [BYTES-1:0]   keep_out,
    output logic               last_out,
    input  logic               ready_out,
    input  logic               valid_hdr,
    input  logic [DATA_WD-1:0] data_hdr,
    input  logic [BYTES-1:0]   keep_hdr,
    output logic               ready_hdr
`ifdef HDR_INS_PKT_CNT_EN
    ,
    output logic [31:0]        pkt_cnt,
    output logic               hdr_drop_err
`endif
);

    hdr_state_e         state_q, state_d;
    logic [CNT_WD-1:0]  hcnt_q, hcnt_d;   // header bytes carried into each output beat
    logic [CNT_WD-1:0]  fcnt_q, fcnt_d;   // valid lanes of the flush beat
    logic [DATA_WD-1:0] res_q, res_d;     // residual bytes, right-aligned
    logic               hdr_en_q;         // holds ready_hdr low during the reset cycle

    logic               slice_rdy;
    logic               push, push_last;
    logic [DATA_WD-1:0] push_data;
    logic [BYTES-1:0]   push_keep;

    int unsigned        h, kcnt;
    logic [BYTES-1:0]   in_msk;
    logic [DATA_WD-1:0] data_msk, beat_data, res_sh, in_sh;

    always_comb begin
        h         = 32'(hcnt_q);
        kcnt      = popcount(MAX_BYTES'(keep_in));
        in_msk    = BYTES'(keep_msk(kcnt, BYTES));
        data_msk  = '0;
        for (int b = 0; b < BYTES; b++) begin
            data_msk[8*b +: 8] = in_msk[b] ? data_in[8*b +: 8] : 8'h00;
        end
        // Last beat: only the lane count matters, bytes are taken from the top.
        beat_data = last_in ? data_msk : data_in;
        // Shifts by a full word yield zero, covering H=0 and H=BYTES.
        res_sh    = res_q << (8 * (BYTES - h));
        in_sh     = beat_data >> (8 * h);

        state_d   = state_q;
        hcnt_d    = hcnt_q;
        fcnt_d    = fcnt_q;
        res_d     = res_q;
        push      = 1'b0;
        push_data = res_sh | in_sh;
        push_keep = '1;
        push_last = 1'b0;
        ready_in  = 1'b0;
        ready_hdr = 1'b0;

        unique case (state_q)
            StIdle: begin
                // Wait until the previous packet's last beat has left the output register.
                ready_hdr = hdr_en_q && !(valid_out && last_out);
                if (valid_hdr && ready_hdr) begin
                    hcnt_d  = CNT_WD'(popcount(MAX_BYTES'(keep_hdr)));
                    res_d   = data_hdr;
                    state_d = StStream;
                end
            end
            StStream: begin
                ready_in = slice_rdy;
                if (valid_in && slice_rdy) begin
                    push  = 1'b1;
                    res_d = beat_data;
                    if (h == 0) begin
                        push_data = data_in;
                        push_keep = keep_in;
                        push_last = last_in;
                        if (last_in) state_d = StIdle;
                    end else if (last_in) begin
                        if (h + kcnt <= BYTES) begin
                            push_keep = BYTES'(keep_msk(h + kcnt, BYTES));
                            push_last = 1'b1;
                            state_d   = StIdle;
                        end else begin
                            fcnt_d  = CNT_WD'(h + kcnt - BYTES);
                            state_d = StFlush;
                        end
                    end
                end
            end
            StFlush: begin
                push      = 1'b1;
                push_data = res_sh;
                push_keep = BYTES'(keep_msk(32'(fcnt_q), BYTES));
                push_last = 1'b1;
                if (slice_rdy) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            hcnt_q   <= '0;
            fcnt_q   <= '0;
            res_q    <= '0;
            hdr_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            hcnt_q   <= hcnt_d;
            fcnt_q   <= fcnt_d;
            res_q    <= res_d;
            hdr_en_q <= 1'b1;
        end
    end

    axis_reg_slice #(
        .WIDTH(DATA_WD + BYTES + 1)
    ) u_out_slice (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_in (push),
        .data_in  ({push_last, push_keep, push_data}),
        .ready_in (slice_rdy),
        .valid_out(valid_out),
        .data_out ({last_out, keep_out, data_out}),
        .ready_out(ready_out)
    );

`ifdef HDR_INS_PKT_CNT_EN
    logic [31:0]      pkt_cnt_q;
    logic             drop_err_q;
    logic [BYTES-1:0] hdr_lsb, hdr_sum;

    // Adding the lowest set bit clears a contiguous run entirely.
    assign hdr_lsb      = keep_hdr & (~keep_hdr + BYTES'(1));
    assign hdr_sum      = keep_hdr + hdr_lsb;
    assign pkt_cnt      = pkt_cnt_q;
    assign hdr_drop_err = drop_err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt_q  <= '0;
            drop_err_q <= 1'b0;
        end else begin
            if (valid_out && ready_out && last_out) pkt_cnt_q <= pkt_cnt_q + 32'd1;
            if (valid_hdr && ((hdr_sum & keep_hdr) != '0)) drop_err_q <= 1'b1;
        end
    end
`endif

endmodule
